// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder slice reused over WIDTH cycles with a
// registered carry, operands accepted via start and result flagged by done.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Carry
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] ps;
    logic [WIDTH-1:0] ps_next;
    logic             cr;
    logic [CW-1:0]    cnt;
    logic             s;
    logic             co;

    // Full adder from two half adders; ps_next drops the oldest bit off the bottom
    always_comb begin
        s       = sa[0] ^ sb[0] ^ cr;
        co      = (sa[0] & sb[0]) | (cr & (sa[0] ^ sb[0]));
        ps_next = {s, {(WIDTH-1){1'b0}}} | (ps >> 1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = ADD;
            ADD:     if (cnt == LAST) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sa    <= '0;
            sb    <= '0;
            ps    <= '0;
            cr    <= 1'b0;
            cnt   <= '0;
            Sum   <= '0;
            Carry <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sa  <= A;
                        sb  <= B;
                        cr  <= Cin;
                        ps  <= '0;
                        cnt <= '0;
                    end
                end
                ADD: begin
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    ps  <= ps_next;
                    cr  <= co;
                    cnt <= cnt + CW'(1);
                    // Result registers only move on the final slice
                    if (cnt == LAST) begin
                        Sum   <= ps_next;
                        Carry <= co;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed and random adds compared
// against a plain-arithmetic reference and an expected-timing model.
module tb_serial_adder;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry;

    int vectors = 0;
    int miscompares = 0;

    logic [WIDTH-1:0] exp_sum;
    logic             exp_carry;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (a),
        .B     (b),
        .Cin   (cin),
        .busy  (busy),
        .done  (done),
        .Sum   (sum),
        .Carry (carry)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH:0] ref_add(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y,
                                               input logic c);
        return {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;
        exp_sum = '0;
        exp_carry = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            vectors++;
            if (busy !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL reset_busy cycle %0d got %b want 0", i, busy);
            end
            vectors++;
            if (done !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL reset_done cycle %0d got %b want 0", i, done);
            end
            vectors++;
            if (sum !== '0 || carry !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL reset_result cycle %0d got %h/%b want 00/0", i, sum, carry);
            end
        end
    endtask

    task automatic test_adds();
        logic [WIDTH-1:0] ta [6] = '{8'h00, 8'h7F, 8'h12, 8'hFF, 8'hA5, 8'hFF};
        logic [WIDTH-1:0] tb [6] = '{8'h00, 8'h01, 8'h34, 8'h01, 8'h5A, 8'hFF};
        logic             tc [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [WIDTH-1:0] va;
        logic [WIDTH-1:0] vb;
        logic             vc;
        logic [WIDTH:0]   full;
        for (int n = 0; n < 26; n++) begin
            if (n < 6) begin
                va = ta[n];
                vb = tb[n];
                vc = tc[n];
            end else begin
                va = WIDTH'($urandom);
                vb = WIDTH'($urandom);
                vc = 1'($urandom);
            end
            full = ref_add(va, vb, vc);
            a = va;
            b = vb;
            cin = vc;
            start = 1'b1;
            tick();
            start = 1'b0;
            a = WIDTH'($urandom);
            b = WIDTH'($urandom);
            cin = 1'($urandom);
            vectors++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL add_accept op %0d got busy=%b done=%b want 1/0", n, busy, done);
            end
            for (int i = 1; i <= WIDTH + 1; i++) begin
                tick();
                if (i == WIDTH) begin
                    exp_sum = full[WIDTH-1:0];
                    exp_carry = full[WIDTH];
                end
                vectors++;
                if (done !== (i == WIDTH) || busy !== (i <= WIDTH)) begin
                    miscompares++;
                    $display("[TB] FAIL add_timing op %0d cycle %0d got busy=%b done=%b want %b/%b",
                             n, i, busy, done, (i <= WIDTH), (i == WIDTH));
                end
                vectors++;
                if (sum !== exp_sum || carry !== exp_carry) begin
                    miscompares++;
                    $display("[TB] FAIL add_result op %0d (%h+%h+%b) cycle %0d got %h/%b want %h/%b",
                             n, va, vb, vc, i, sum, carry, exp_sum, exp_carry);
                end
            end
        end
    endtask

    task automatic test_busy();
        int done_count = 0;
        a = 8'h10;
        b = 8'h20;
        cin = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i <= WIDTH + 4; i++) begin
            if (i == 3 || i == 9) begin
                a = 8'hFF;
                b = 8'hFF;
                cin = 1'b1;
                start = 1'b1;
            end
            tick();
            start = 1'b0;
            a = WIDTH'($urandom);
            b = WIDTH'($urandom);
            if (done === 1'b1) done_count++;
            if (i == WIDTH) begin
                exp_sum = 8'h30;
                exp_carry = 1'b0;
            end
            vectors++;
            if (busy !== (i <= WIDTH) || done !== (i == WIDTH)) begin
                miscompares++;
                $display("[TB] FAIL busy_timing cycle %0d got busy=%b done=%b want %b/%b",
                         i, busy, done, (i <= WIDTH), (i == WIDTH));
            end
            vectors++;
            if (sum !== exp_sum || carry !== exp_carry) begin
                miscompares++;
                $display("[TB] FAIL busy_result cycle %0d got %h/%b want %h/%b",
                         i, sum, carry, exp_sum, exp_carry);
            end
        end
        vectors++;
        if (done_count != 1) begin
            miscompares++;
            $display("[TB] FAIL busy_done_count got %0d want 1", done_count);
        end
    endtask

    task automatic test_mid_reset();
        a = 8'hFF;
        b = 8'h01;
        cin = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_sum = '0;
        exp_carry = 1'b0;
        for (int i = 0; i < 12; i++) begin
            vectors++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL midrst_status cycle %0d got busy=%b done=%b want 0/0", i, busy, done);
            end
            vectors++;
            if (sum !== exp_sum || carry !== exp_carry) begin
                miscompares++;
                $display("[TB] FAIL midrst_result cycle %0d got %h/%b want 00/0", i, sum, carry);
            end
            tick();
        end
        a = 8'h01;
        b = 8'h02;
        cin = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i <= WIDTH + 1; i++) begin
            tick();
            if (i == WIDTH) exp_sum = 8'h03;
            vectors++;
            if (done !== (i == WIDTH) || sum !== exp_sum || carry !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL midrst_next cycle %0d got done=%b sum=%h carry=%b want %b/%h/0",
                         i, done, sum, carry, (i == WIDTH), exp_sum);
            end
        end
    endtask

    task automatic test_back_to_back();
        localparam int PERIOD = WIDTH + 2;
        logic [WIDTH:0] pending = '0;
        a = WIDTH'($urandom);
        b = WIDTH'($urandom);
        cin = 1'($urandom);
        start = 1'b1;
        for (int c = 0; c < 3 * PERIOD; c++) begin
            if (c % PERIOD == 0) pending = ref_add(a, b, cin);
            tick();
            if (c % PERIOD == WIDTH) begin
                exp_sum = pending[WIDTH-1:0];
                exp_carry = pending[WIDTH];
            end
            vectors++;
            if (done !== (c % PERIOD == WIDTH) || busy !== (c % PERIOD != WIDTH + 1)) begin
                miscompares++;
                $display("[TB] FAIL b2b_timing cycle %0d got busy=%b done=%b want %b/%b",
                         c, busy, done, (c % PERIOD != WIDTH + 1), (c % PERIOD == WIDTH));
            end
            vectors++;
            if (sum !== exp_sum || carry !== exp_carry) begin
                miscompares++;
                $display("[TB] FAIL b2b_result cycle %0d got %h/%b want %h/%b",
                         c, sum, carry, exp_sum, exp_carry);
            end
            a = WIDTH'($urandom);
            b = WIDTH'($urandom);
            cin = 1'($urandom);
        end
        start = 1'b0;
        tick();
        vectors++;
        if (busy !== 1'b0 || sum !== exp_sum) begin
            miscompares++;
            $display("[TB] FAIL b2b_stop got busy=%b sum=%h want 0/%h", busy, sum, exp_sum);
        end
    endtask

    initial begin
        test_reset();
        test_adds();
        test_busy();
        test_mid_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

endmodule
